// File: rtl/mem_wb_stage_pkg.sv
// Shared constants for the MEM/WB boundary: load-size encodings, default widths and
// the hard-wired zero register index.
package mem_wb_stage_pkg;

  localparam int unsigned DW_DEFAULT = 32;
  localparam int unsigned RW_DEFAULT = 5;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Load-data lane extraction and sign/zero extension for byte, half and word loads.
module mem_wb_stage_load_extend
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT
) (
  input  logic [DW-1:0] raw_i,
  input  logic [1:0]    addr_lo_i,
  input  logic [1:0]    ld_size_i,
  input  logic          ld_uns_i,
  output logic [DW-1:0] data_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = raw_i[{addr_lo_i, 3'b000} +: 8];
    // Half-word lanes ignore the low address bit.
    half_lane = raw_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (ld_size_i)
      LD_BYTE: data_o = ld_uns_i ? {{(DW-8){1'b0}}, byte_lane}
                                 : {{(DW-8){byte_lane[7]}}, byte_lane};
      LD_HALF: data_o = ld_uns_i ? {{(DW-16){1'b0}}, half_lane}
                                 : {{(DW-16){half_lane[15]}}, half_lane};
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline boundary: aligns control with the one-cycle-late SRAM data, extracts
// load data, drives the register-file write port and counts retired instructions.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DW = DW_DEFAULT,
  parameter int unsigned RW = RW_DEFAULT,
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  input  logic          stall_i,
  input  logic          flush_i,
  input  logic [DW-1:0] alu_result_i,
  input  logic          MemRead_i,
  input  logic          MemtoReg_i,
  input  logic          RegWrite_i,
  input  logic [RW-1:0] rd_i,
  input  logic [1:0]    ld_size_i,
  input  logic          ld_unsigned_i,
  input  logic [DW-1:0] mem_read_data,
  output logic          reg_wen_o,
  output logic [RW-1:0] reg_waddr_o,
  output logic [DW-1:0] reg_wdata_o,
  output logic          wb_valid_o,
  output logic [CW-1:0] retire_cnt_o
);

  logic          v_q, rw_q, m2r_q, ld_uns_q, held_q;
  logic [RW-1:0] rd_q;
  logic [1:0]    ld_size_q, addr_lo_q;
  logic [DW-1:0] alu_q, hdata_q;
  logic [CW-1:0] retire_q;
  logic [DW-1:0] raw_data, ext_data;

  // Load vs. non-load is already fully captured by MemtoReg_i.
  logic unused_memread;
  assign unused_memread = MemRead_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q       <= 1'b0;
      rw_q      <= 1'b0;
      m2r_q     <= 1'b0;
      rd_q      <= '0;
      ld_size_q <= '0;
      ld_uns_q  <= 1'b0;
      alu_q     <= '0;
      addr_lo_q <= '0;
      hdata_q   <= '0;
      held_q    <= 1'b0;
      retire_q  <= '0;
    end else if (flush_i) begin
      v_q    <= 1'b0;
      held_q <= 1'b0;
    end else if (stall_i) begin
      // SRAM data is only valid in the first WB cycle; keep it for the rest of the stall.
      if (v_q && !held_q) begin
        hdata_q <= mem_read_data;
        held_q  <= 1'b1;
      end
    end else begin
      if (v_q) retire_q <= retire_q + CW'(1);
      v_q       <= valid_i;
      rw_q      <= RegWrite_i;
      m2r_q     <= MemtoReg_i;
      rd_q      <= rd_i;
      ld_size_q <= ld_size_i;
      ld_uns_q  <= ld_unsigned_i;
      alu_q     <= alu_result_i;
      addr_lo_q <= alu_result_i[1:0];
      held_q    <= 1'b0;
    end
  end

  assign raw_data = held_q ? hdata_q : mem_read_data;

  mem_wb_stage_load_extend #(
    .DW(DW)
  ) u_load_extend (
    .raw_i    (raw_data),
    .addr_lo_i(addr_lo_q),
    .ld_size_i(ld_size_q),
    .ld_uns_i (ld_uns_q),
    .data_o   (ext_data)
  );

  assign reg_wdata_o  = m2r_q ? ext_data : alu_q;
  assign reg_waddr_o  = rd_q;
  assign wb_valid_o   = v_q;
  assign reg_wen_o    = v_q & rw_q & (rd_q != RW'(REG_ZERO)) & ~stall_i;
  assign retire_cnt_o = retire_q;

endmodule
